// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: shared FSM state type, table word type and default codec register table
package codec_cfg_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAP, FIN, ERR} cfg_state_t;
  typedef logic [15:0] cfg_word_t;
  localparam cfg_word_t CODEC_DEFAULT_TBL [16] = '{
    16'h0815, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1019, 16'h1201, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
  };
endpackage

// File: rtl/codec_cfg_if.sv
// codec_cfg_if: START/DONE write handshake between the sequencer and the I2C_AUD master
interface codec_cfg_if;
  logic       start;
  logic [7:0] dev_addr;
  logic [7:0] secdata;
  logic [7:0] thirddata;
  logic       done;
  logic       ack_err;
  modport master (output start, dev_addr, secdata, thirddata, input done, ack_err);
  modport slave (input start, dev_addr, secdata, thirddata, output done, ack_err);
endinterface

// File: rtl/codec_cfg_table.sv
// codec_cfg_table: constant register table, or a writable copy of it when CODEC_CFG_WRITE_EN is defined
module codec_cfg_table
  import codec_cfg_pkg::*;
(
`ifdef CODEC_CFG_WRITE_EN
  input  logic      Clk,
  input  logic      Reset_n,
  input  logic      busy,
  input  logic      we,
  input  logic [3:0] waddr,
  input  cfg_word_t wdata,
`endif
  input  logic [3:0] idx,
  output cfg_word_t  word
);
`ifdef CODEC_CFG_WRITE_EN
  cfg_word_t tbl_q [16];
  cfg_word_t tbl_d [16];
  always_comb begin
    tbl_d = tbl_q;
    if (we && !busy) tbl_d[waddr] = wdata;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) tbl_q <= CODEC_DEFAULT_TBL;
    else tbl_q <= tbl_d;
  assign word = tbl_q[idx];
`else
  assign word = CODEC_DEFAULT_TBL[idx];
`endif
endmodule

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: walks the codec table issuing I2C writes with retry, timeout and gap; CODEC_CFG_WRITE_EN adds table write ports
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int         NUM_REGS    = 6,
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter int         RETRY_MAX   = 3,
  parameter int         GAP_CYCLES  = 64,
  parameter int         TIMEOUT_CYC = 2**20,
  parameter bit         AUTO_START  = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        cfg_go,
  codec_cfg_if.master i2c,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
`ifdef CODEC_CFG_WRITE_EN
  input  logic        tbl_we,
  input  logic [3:0]  tbl_waddr,
  input  cfg_word_t   tbl_wdata,
`endif
  output logic [3:0]  cfg_index
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  cfg_state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [2:0] retry_q, retry_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] to_q, to_d;
  logic start_q, start_d, busy_q, busy_d, done_q, done_d, err_q, err_d, auto_q, auto_d;
  logic [7:0] sec_q, sec_d, third_q, third_d;
  logic last_ok;
  cfg_word_t word;
  codec_cfg_table u_tbl (
`ifdef CODEC_CFG_WRITE_EN
    .Clk(Clk), .Reset_n(Reset_n), .busy(busy_q), .we(tbl_we), .waddr(tbl_waddr), .wdata(tbl_wdata),
`endif
    .idx(idx_q), .word(word)
  );
  assign last_ok = retry_q == 3'd0 && idx_q == 4'(NUM_REGS - 1);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    gap_d   = gap_q;
    to_d    = to_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    sec_d   = sec_q;
    third_d = third_q;
    auto_d  = 1'b0;
    start_d = state_q == START;
    case (state_q)
      IDLE: if (cfg_go || auto_q) begin
        state_d = LOAD;
        idx_d   = 4'd0;
        retry_d = 3'd0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
      LOAD: begin
        sec_d   = word[15:8];
        third_d = word[7:0];
        state_d = START;
      end
      START: begin
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: if (i2c.done && !i2c.ack_err) begin
        retry_d = 3'd0;
        gap_d   = '0;
        state_d = GAP;
      end else if (i2c.done || to_q == TW'(TIMEOUT_CYC - 1)) begin
        retry_d = retry_q < 3'(RETRY_MAX) ? retry_q + 3'd1 : retry_q;
        gap_d   = '0;
        state_d = retry_q < 3'(RETRY_MAX) ? GAP : ERR;
      end else begin
        to_d = to_q + 1'b1;
      end
      GAP: if (gap_q == GW'(GAP_CYCLES - 1)) begin
        state_d = last_ok ? FIN : LOAD;
        idx_d   = retry_q == 3'd0 && !last_ok ? idx_q + 4'd1 : idx_q;
      end else begin
        gap_d = gap_q + 1'b1;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      retry_q <= 3'd0;
      gap_q   <= '0;
      to_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sec_q   <= 8'd0;
      third_q <= 8'd0;
      auto_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sec_q   <= sec_d;
      third_q <= third_d;
      auto_q  <= auto_d;
    end
  assign i2c.start     = start_q;
  assign i2c.dev_addr  = DEV_ADDR;
  assign i2c.secdata   = sec_q;
  assign i2c.thirddata = third_q;
  assign cfg_busy      = busy_q;
  assign cfg_done      = done_q;
  assign cfg_error     = err_q;
  assign cfg_index     = idx_q;
endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// tb_codec_cfg_sequencer: randomized I2C slave model with a transaction-level expectation of the write sequence
module tb_codec_cfg_sequencer;
  localparam int NUM = 6, RMAX = 3, GAP = 8, TMO = 100;
  localparam int M_ACK = 0, M_NACK2 = 1, M_NACK3 = 2, M_NODONE = 3;
  logic Clk = 1'b0, Reset_n = 1'b0, cfg_go = 1'b0;
  logic cfg_busy, cfg_done, cfg_error;
  logic [3:0] cfg_index;
  logic done_m = 1'b0, done_s = 1'b0, ack_m = 1'b0;
`ifdef CODEC_CFG_WRITE_EN
  logic tbl_we = 1'b0;
  logic [3:0] tbl_waddr = 4'd0;
  logic [15:0] tbl_wdata = 16'd0;
`endif
  codec_cfg_if bus ();
  assign bus.done    = done_m | done_s;
  assign bus.ack_err = ack_m;
  codec_cfg_sequencer #(
    .NUM_REGS(NUM), .DEV_ADDR(8'h34), .RETRY_MAX(RMAX),
    .GAP_CYCLES(GAP), .TIMEOUT_CYC(TMO), .AUTO_START(1'b1)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .cfg_go(cfg_go), .i2c(bus),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
`ifdef CODEC_CFG_WRITE_EN
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
`endif
    .cfg_index(cfg_index)
  );
  always #10 Clk = ~Clk;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, t0 = 0, mode = M_ACK, cnt = 0, ent = 0, lat_lo = 1, lat_hi = 12;
  bit used2 = 1'b0, nack = 1'b0, e_err = 1'b0;
  int e_idx = 0;
  logic [15:0] tbl_m [NUM] = '{16'h0815, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1019, 16'h1201};
  logic [15:0] wlog [$];
  logic [15:0] exp_q [$];
  int scyc [$];
  int dcyc [$];

  function automatic int find_entry(input logic [7:0] sec);
    for (int i = 0; i < NUM; i++) if (tbl_m[i][15:8] == sec) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      cyc++;
      done_m = 1'b0;
      ack_m  = 1'($urandom_range(0, 1));
      if (!Reset_n) cnt = 0;
      else if (bus.start) begin
        wlog.push_back({bus.secdata, bus.thirddata});
        scyc.push_back(cyc);
        ent  = find_entry(bus.secdata);
        nack = (mode == M_NACK3 && ent == 3) || (mode == M_NACK2 && ent == 2 && !used2);
        if (mode == M_NACK2 && ent == 2) used2 = 1'b1;
        cnt = mode == M_NODONE ? 0 : int'($urandom_range(lat_lo, lat_hi));
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          done_m = 1'b1;
          ack_m  = nack;
          dcyc.push_back(cyc);
        end
      end
    end
  end

  task automatic build_exp();
    exp_q.delete();
    e_err = 1'b0;
    e_idx = NUM - 1;
    for (int i = 0; i < NUM; i++) begin
      int fails;
      fails = (mode == M_NACK2 && i == 2) ? 1 :
              ((mode == M_NACK3 && i == 3) || mode == M_NODONE) ? 99 : 0;
      repeat (fails > RMAX ? RMAX + 1 : fails + 1) exp_q.push_back(tbl_m[i]);
      if (fails > RMAX) begin
        e_err = 1'b1;
        e_idx = i;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    wlog.delete();
    scyc.delete();
    dcyc.delete();
    used2 = 1'b0;
  endtask

  task automatic go_pulse();
    @(negedge Clk);
    #1;
    clear_logs();
    t0 = cyc;
    cfg_go = 1'b1;
    @(negedge Clk);
    #1;
    cfg_go = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_start"}, 32'(bus.start), 0);
    chk({nm, "_busy"}, 32'(cfg_busy), 0);
    chk({nm, "_done"}, 32'(cfg_done), 0);
    chk({nm, "_error"}, 32'(cfg_error), 0);
    chk({nm, "_index"}, 32'(cfg_index), 0);
    chk({nm, "_secdata"}, 32'(bus.secdata), 0);
    chk({nm, "_thirddata"}, 32'(bus.thirddata), 0);
  endtask

  task automatic finish_run(input string nm, input bit noise);
    int n;
    n = 0;
    build_exp();
    while ((cfg_busy || n < 3) && n < 4000) begin
      @(negedge Clk);
      #1;
      n++;
      if (noise && cfg_busy && $urandom_range(0, 15) == 0) begin
        cfg_go = 1'b1;
        @(negedge Clk);
        #1;
        cfg_go = 1'b0;
        n++;
      end
    end
    chk({nm, "_completes"}, 32'(cfg_busy), 0);
    repeat (150) @(negedge Clk);
    #1;
    chk({nm, "_nwrites"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      chk($sformatf("%s_word%0d", nm, i), 32'(wlog[i]), 32'(exp_q[i]));
    if (scyc.size() > 0) chk({nm, "_first_start_lat"}, scyc[0] - t0, 3);
    for (int i = 1; i < scyc.size(); i++)
      if (mode == M_NODONE) chk($sformatf("%s_tmo_space%0d", nm, i), scyc[i] - scyc[i-1], TMO + GAP + 2);
      else if (dcyc.size() >= i) chk($sformatf("%s_gap%0d", nm, i), scyc[i] - dcyc[i-1], GAP + 3);
    chk({nm, "_busy"}, 32'(cfg_busy), 0);
    chk({nm, "_done"}, 32'(cfg_done), 32'(!e_err));
    chk({nm, "_error"}, 32'(cfg_error), 32'(e_err));
    chk({nm, "_index"}, 32'(cfg_index), e_idx);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge Clk);
    #1;
    chk_reset("por");
    chk("dev_addr", 32'(bus.dev_addr), 32'h34);
    mode = M_ACK;
    clear_logs();
    t0 = cyc;
    Reset_n = 1'b1;
    finish_run("auto", 1'b0);
    mode = M_ACK;
    go_pulse();
    finish_run("go_noise", 1'b1);
    mode = M_NACK2;
    go_pulse();
    finish_run("nack2", 1'b0);
    mode = M_NACK3;
    go_pulse();
    finish_run("nack3", 1'b1);
    mode = M_NODONE;
    go_pulse();
    finish_run("tmo", 1'b0);
    mode = M_ACK;
    go_pulse();
    finish_run("after_err", 1'b0);
    lat_lo = 20;
    lat_hi = 20;
    go_pulse();
    n = 0;
    while (wlog.size() < 2 && n < 500) begin
      @(negedge Clk);
      #1;
      n++;
    end
    chk("rst_reach_entry1", wlog.size(), 2);
    repeat (3) @(negedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (2) @(negedge Clk);
    #1;
    clear_logs();
    lat_lo = 1;
    lat_hi = 12;
    t0 = cyc;
    Reset_n = 1'b1;
    done_s = 1'b1;
    @(negedge Clk);
    #1;
    done_s = 1'b0;
    finish_run("rst_rerun", 1'b0);
`ifdef CODEC_CFG_WRITE_EN
    @(negedge Clk);
    #1;
    tbl_we = 1'b1;
    tbl_waddr = 4'd0;
    tbl_wdata = 16'h0817;
    tbl_m[0] = 16'h0817;
    @(negedge Clk);
    #1;
    tbl_we = 1'b0;
    go_pulse();
    repeat (4) @(negedge Clk);
    #1;
    tbl_we = 1'b1;
    tbl_waddr = 4'd1;
    tbl_wdata = 16'hFFFF;
    @(negedge Clk);
    #1;
    tbl_we = 1'b0;
    finish_run("tbl_write", 1'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
